// File: rtl/custom_axi_ip_regs_if.sv
`default_nettype none
// ============================================================================
//  Module      : custom_axi_ip_regs_if
//  Description : AXI4-Lite bus bundle between a master and the
//                custom_axi_ip_regs register slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface custom_axi_ip_regs_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/custom_axi_ip_regs.sv
`default_nettype none
// ============================================================================
//  Module      : custom_axi_ip_regs
//  Description : AXI4-Lite register bank feeding the custom_axi_ip core:
//                64-bit operand, start pulse, status, 64-bit result and a
//                wrapping completion counter. Define CUSTOM_AXI_IP_REGS_IRQ_EN
//                to add the W1C completion interrupt at 0x1C and irq_o.
//  Revision    : 1.0  initial release
// ============================================================================
package custom_axi_ip_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_e;
endpackage

module custom_axi_ip_regs
    import custom_axi_ip_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    custom_axi_ip_regs_if.slave s_axi,
    output logic [63:0]        ipreg_data_o,
    output logic               enable_o,
    input  wire logic [63:0]   ipreg_data_i,
    input  wire status_e       status_i,
    input  wire logic          wen_i
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
    ,
    output logic               irq_o
`endif
);

    localparam logic [2:0] C_IDX_CTRL     = 3'd0;
    localparam logic [2:0] C_IDX_STATUS   = 3'd1;
    localparam logic [2:0] C_IDX_DIN_LO   = 3'd2;
    localparam logic [2:0] C_IDX_DIN_HI   = 3'd3;
    localparam logic [2:0] C_IDX_DOUT_LO  = 3'd4;
    localparam logic [2:0] C_IDX_DOUT_HI  = 3'd5;
    localparam logic [2:0] C_IDX_DONE_CNT = 3'd6;
    localparam logic [2:0] C_IDX_IRQ      = 3'd7;

    localparam logic [1:0] C_RESP_OKAY    = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_DATA = 2'd2
    } rstate_e;

    wstate_e               r_wstate;
    rstate_e               r_rstate;

    logic [DATA_WIDTH-1:0] r_din_lo;
    logic [DATA_WIDTH-1:0] r_din_hi;
    logic [31:0]           r_dout_lo;
    logic [31:0]           r_dout_hi;
    logic [31:0]           r_done_cnt;

    logic [2:0]            w_wr_idx;
    logic [2:0]            w_rd_idx;
    logic                  w_bit0_set;
    logic                  w_wr_err;
    logic                  w_rd_err;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused;

    assign w_wr_idx     = s_axi.awaddr[4:2];
    assign w_rd_idx     = s_axi.araddr[4:2];
    assign w_bit0_set   = s_axi.wdata[0] & s_axi.wstrb[0];
    assign ipreg_data_o = {r_din_hi, r_din_lo};

    // Only the word index is decoded; the remaining address bits alias.
    assign w_unused = ^{s_axi.awaddr[ADDR_WIDTH-1:5], s_axi.awaddr[1:0],
                        s_axi.araddr[ADDR_WIDTH-1:5], s_axi.araddr[1:0]};

    function automatic logic [DATA_WIDTH-1:0] f_strb_merge(
        input logic [DATA_WIDTH-1:0]   old_v,
        input logic [DATA_WIDTH-1:0]   new_v,
        input logic [DATA_WIDTH/8-1:0] strb
    );
        logic [DATA_WIDTH-1:0] v;
        v = old_v;
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (strb[i]) begin
                v[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return v;
    endfunction

    // A START request while the core is not idle is refused with SLVERR.
    always_comb begin
        w_wr_err = 1'b0;
        case (w_wr_idx)
            C_IDX_CTRL:   w_wr_err = w_bit0_set && (status_i != IDLE);
            C_IDX_DIN_LO: w_wr_err = 1'b0;
            C_IDX_DIN_HI: w_wr_err = 1'b0;
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
            C_IDX_IRQ:    w_wr_err = 1'b0;
`endif
            default:      w_wr_err = 1'b1;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (w_rd_idx)
            C_IDX_CTRL:     w_rd_data = '0;
            C_IDX_STATUS:   w_rd_data = {{(DATA_WIDTH-2){1'b0}}, status_i};
            C_IDX_DIN_LO:   w_rd_data = r_din_lo;
            C_IDX_DIN_HI:   w_rd_data = r_din_hi;
            C_IDX_DOUT_LO:  w_rd_data = r_dout_lo;
            C_IDX_DOUT_HI:  w_rd_data = r_dout_hi;
            C_IDX_DONE_CNT: w_rd_data = r_done_cnt;
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
            C_IDX_IRQ:      w_rd_data = {{(DATA_WIDTH-1){1'b0}}, irq_o};
`endif
            default:        w_rd_err  = 1'b1;
        endcase
    end

    // Write channel: address and data are only ever accepted together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wstate      <= W_IDLE;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= C_RESP_OKAY;
            enable_o      <= 1'b0;
            r_din_lo      <= '0;
            r_din_hi      <= '0;
        end else begin
            enable_o <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (s_axi.awvalid && s_axi.wvalid) begin
                        s_axi.awready <= 1'b1;
                        s_axi.wready  <= 1'b1;
                        r_wstate      <= W_ACK;
                    end
                end
                W_ACK: begin
                    s_axi.awready <= 1'b0;
                    s_axi.wready  <= 1'b0;
                    s_axi.bvalid  <= 1'b1;
                    s_axi.bresp   <= w_wr_err ? C_RESP_SLVERR : C_RESP_OKAY;
                    if (!w_wr_err) begin
                        case (w_wr_idx)
                            C_IDX_CTRL:   enable_o <= w_bit0_set;
                            C_IDX_DIN_LO: r_din_lo <= f_strb_merge(r_din_lo, s_axi.wdata, s_axi.wstrb);
                            C_IDX_DIN_HI: r_din_hi <= f_strb_merge(r_din_hi, s_axi.wdata, s_axi.wstrb);
                            default:      ;
                        endcase
                    end
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        s_axi.bvalid <= 1'b0;
                        r_wstate     <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel: data is sampled on the arready edge and then held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rstate      <= R_IDLE;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= C_RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_axi.arvalid) begin
                        s_axi.arready <= 1'b1;
                        r_rstate      <= R_ACK;
                    end
                end
                R_ACK: begin
                    s_axi.arready <= 1'b0;
                    s_axi.rvalid  <= 1'b1;
                    s_axi.rdata   <= w_rd_data;
                    s_axi.rresp   <= w_rd_err ? C_RESP_SLVERR : C_RESP_OKAY;
                    r_rstate      <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        s_axi.rvalid <= 1'b0;
                        r_rstate     <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Result capture from the core.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dout_lo  <= '0;
            r_dout_hi  <= '0;
            r_done_cnt <= '0;
        end else if (wen_i) begin
            r_dout_lo  <= ipreg_data_i[31:0];
            r_dout_hi  <= ipreg_data_i[63:32];
            r_done_cnt <= r_done_cnt + 32'd1;
        end
    end

`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
    logic w_irq_clr;
    assign w_irq_clr = (r_wstate == W_ACK) && (w_wr_idx == C_IDX_IRQ) && w_bit0_set;

    // A new completion on the same edge as a clear keeps the bit pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_o <= 1'b0;
        end else if (wen_i) begin
            irq_o <= 1'b1;
        end else if (w_irq_clr) begin
            irq_o <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_custom_axi_ip_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_custom_axi_ip_regs
//  Description : Scoreboard bench for custom_axi_ip_regs (AXI-Lite accesses,
//                START, result capture, collisions, async reset).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_custom_axi_ip_regs;
    import custom_axi_ip_pkg::*;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] ipreg_data_o;
    logic [63:0] ipreg_data_i;
    logic        enable_o;
    logic        wen_i;
    status_e     status_i;
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
    logic        irq_o;
`endif

    always #5 clk = ~clk;

    custom_axi_ip_regs_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) s_axi ();

    custom_axi_ip_regs dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .s_axi        (s_axi),
        .ipreg_data_o (ipreg_data_o),
        .enable_o     (enable_o),
        .ipreg_data_i (ipreg_data_i),
        .status_i     (status_i),
        .wen_i        (wen_i)
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
        ,
        .irq_o        (irq_o)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        rd_q[$];
    exp_t        wr_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          en_cnt   = 0;
    logic        last_en;

    logic [31:0] m_din_lo;
    logic [31:0] m_din_hi;
    logic [63:0] m_dout;
    logic [31:0] m_cnt;
    logic        m_irq;

    always @(negedge clk) if (enable_o) en_cnt++;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic capture(input logic [63:0] d);
        m_dout = d;
        m_cnt  = m_cnt + 32'd1;
        m_irq  = 1'b1;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp,
                             input string tag, input bit wen_at_ack = 1'b0,
                             input logic [63:0] wen_data = 64'h0);
        exp_t e;
        int   n;
        wr_q.push_back('{tag: tag, data: 32'h0, resp: exp_resp});
        @(negedge clk);
        s_axi.awaddr  = addr;
        s_axi.wdata   = data;
        s_axi.wstrb   = strb;
        s_axi.awvalid = 1'b1;
        s_axi.wvalid  = 1'b1;
        n = 0;
        while (!(s_axi.awready && s_axi.wready) && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_wready"}, 64'(s_axi.awready & s_axi.wready), 64'd1);
        if (wen_at_ack) begin
            ipreg_data_i = wen_data;
            wen_i        = 1'b1;
        end
        @(posedge clk);
        #1;
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        wen_i         = 1'b0;
        s_axi.bready  = 1'b1;
        n = 0;
        while (!s_axi.bvalid && n < 16) begin
            @(negedge clk);
            n++;
        end
        last_en = enable_o;
        check_val({tag, "_bvalid"}, 64'(s_axi.bvalid), 64'd1);
        e = wr_q.pop_front();
        check_val({e.tag, "_bresp"}, 64'(s_axi.bresp), 64'(e.resp));
        @(posedge clk);
        #1 s_axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input string tag,
                            input bit wen_at_ack = 1'b0, input logic [63:0] wen_data = 64'h0);
        exp_t e;
        int   n;
        rd_q.push_back('{tag: tag, data: exp_data, resp: exp_resp});
        @(negedge clk);
        s_axi.araddr  = addr;
        s_axi.arvalid = 1'b1;
        n = 0;
        while (!s_axi.arready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_arready"}, 64'(s_axi.arready), 64'd1);
        if (wen_at_ack) begin
            ipreg_data_i = wen_data;
            wen_i        = 1'b1;
        end
        @(posedge clk);
        #1;
        s_axi.arvalid = 1'b0;
        wen_i         = 1'b0;
        s_axi.rready  = 1'b1;
        n = 0;
        while (!s_axi.rvalid && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_rvalid"}, 64'(s_axi.rvalid), 64'd1);
        e = rd_q.pop_front();
        check_val({e.tag, "_rdata"}, 64'(s_axi.rdata), 64'(e.data));
        check_val({e.tag, "_rresp"}, 64'(s_axi.rresp), 64'(e.resp));
        @(posedge clk);
        #1 s_axi.rready = 1'b0;
    endtask

    task automatic pulse_wen(input logic [63:0] d);
        @(negedge clk);
        ipreg_data_i = d;
        wen_i        = 1'b1;
        @(negedge clk);
        wen_i        = 1'b0;
        capture(d);
    endtask

    task automatic model_reset();
        m_din_lo = 32'h0;
        m_din_hi = 32'h0;
        m_dout   = 64'h0;
        m_cnt    = 32'h0;
        m_irq    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_before;
        s_axi.awaddr  = '0;
        s_axi.awvalid = 1'b0;
        s_axi.wdata   = '0;
        s_axi.wstrb   = '0;
        s_axi.wvalid  = 1'b0;
        s_axi.bready  = 1'b0;
        s_axi.araddr  = '0;
        s_axi.arvalid = 1'b0;
        s_axi.rready  = 1'b0;
        ipreg_data_i  = 64'h0;
        wen_i         = 1'b0;
        status_i      = IDLE;
        model_reset();

        repeat (3) @(negedge clk);
        check_val("rst_ipreg_data", ipreg_data_o, 64'h0);
        check_val("rst_handshake", 64'({s_axi.awready, s_axi.wready, s_axi.bvalid,
                                        s_axi.arready, s_axi.rvalid, enable_o}), 64'h0);
        check_val("rst_resp_rdata", 64'({s_axi.bresp, s_axi.rresp, s_axi.rdata}), 64'h0);
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
        check_val("rst_irq", 64'(irq_o), 64'h0);
`endif
        rst = 1'b0;

        axi_read(8'h08, 32'h0, OKAY, "rst_din_lo");
        axi_read(8'h18, 32'h0, OKAY, "rst_done_cnt");
        axi_read(8'h04, 32'h0, OKAY, "rst_status");

        // operand load and byte strobes
        axi_write(8'h08, 32'h0000_0005, 4'hF, OKAY, "din_lo");
        m_din_lo = 32'h0000_0005;
        axi_write(8'h0C, 32'h0000_000A, 4'hF, OKAY, "din_hi");
        m_din_hi = 32'h0000_000A;
        check_val("ipreg_data", ipreg_data_o, 64'h0000_000A_0000_0005);
        axi_write(8'h08, 32'hFFFF_FFFF, 4'h1, OKAY, "din_lo_strb1");
        m_din_lo = 32'h0000_00FF;
        check_val("ipreg_data_strb", ipreg_data_o, {m_din_hi, m_din_lo});
        axi_write(8'h0C, 32'hFFFF_FFFF, 4'h0, OKAY, "din_hi_strb0");
        axi_read(8'h0C, m_din_hi, OKAY, "din_hi_rb");

        // START with the core idle and busy
        en_before = en_cnt;
        axi_write(8'h00, 32'h1, 4'hF, OKAY, "start_idle");
        check_val("start_en_at_resp", 64'(last_en), 64'd1);
        repeat (2) @(negedge clk);
        check_val("start_pulse_width", 64'(en_cnt - en_before), 64'd1);
        axi_read(8'h00, 32'h0, OKAY, "ctrl_rd");
        status_i  = BUSY;
        en_before = en_cnt;
        axi_write(8'h00, 32'h1, 4'hF, SLVERR, "start_busy");
        repeat (2) @(negedge clk);
        check_val("start_busy_pulse", 64'(en_cnt - en_before), 64'd0);
        axi_read(8'h04, 32'h1, OKAY, "status_busy");
        axi_write(8'h0C, 32'h0000_0077, 4'hF, OKAY, "din_hi_busy");
        m_din_hi = 32'h0000_0077;
        check_val("ipreg_data_busy", ipreg_data_o, {m_din_hi, m_din_lo});
        status_i = IDLE;

        // result capture
        pulse_wen(64'h1234_5678_9ABC_DEF0);
        axi_read(8'h10, 32'h9ABC_DEF0, OKAY, "dout_lo");
        axi_read(8'h14, 32'h1234_5678, OKAY, "dout_hi");
        axi_read(8'h18, 32'h0000_0001, OKAY, "done_cnt1");

        // errors leave state untouched
        axi_write(8'h04, 32'hFFFF_FFFF, 4'hF, SLVERR, "wr_status_ro");
        axi_write(8'h10, 32'hFFFF_FFFF, 4'hF, SLVERR, "wr_dout_ro");
        axi_read(8'h10, m_dout[31:0], OKAY, "dout_lo_kept");
        check_val("ipreg_data_kept", ipreg_data_o, {m_din_hi, m_din_lo});
`ifndef CUSTOM_AXI_IP_REGS_IRQ_EN
        axi_read(8'h3C, 32'h0, SLVERR, "rd_unmapped_3c");
        axi_read(8'h1C, 32'h0, SLVERR, "rd_unmapped_1c");
        axi_write(8'h1C, 32'h1, 4'hF, SLVERR, "wr_unmapped_1c");
`endif

        // DATA_OUT sample and capture on the same edge returns the old value
        axi_read(8'h10, m_dout[31:0], OKAY, "dout_collide", 1'b1, 64'hCAFE_F00D_0BAD_BEEF);
        capture(64'hCAFE_F00D_0BAD_BEEF);
        axi_read(8'h10, 32'h0BAD_BEEF, OKAY, "dout_after_collide");
        axi_read(8'h18, 32'h0000_0002, OKAY, "done_cnt2");

        // counter wrap via backdoor preload
        @(negedge clk);
        force dut.r_done_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_done_cnt;
        m_cnt = 32'hFFFF_FFFF;
        axi_read(8'h18, m_cnt, OKAY, "done_cnt_preload");
        pulse_wen(64'h0000_0001_0000_0002);
        axi_read(8'h18, 32'h0, OKAY, "done_cnt_wrap");

`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
        check_val("irq_pending", 64'(irq_o), 64'(m_irq));
        axi_write(8'h1C, 32'h1, 4'hF, OKAY, "irq_w1c_collide", 1'b1, 64'h5555_AAAA_5555_AAAA);
        capture(64'h5555_AAAA_5555_AAAA);
        @(negedge clk);
        check_val("irq_set_wins", 64'(irq_o), 64'd1);
        axi_read(8'h1C, 32'h1, OKAY, "irq_rd1");
        axi_write(8'h1C, 32'h1, 4'hF, OKAY, "irq_w1c_clean");
        m_irq = 1'b0;
        @(negedge clk);
        check_val("irq_cleared", 64'(irq_o), 64'(m_irq));
        pulse_wen(64'h0);
        check_val("irq_reset_by_wen", 64'(irq_o), 64'd1);
        axi_write(8'h1C, 32'h1, 4'hF, OKAY, "irq_w1c_again");
        m_irq = 1'b0;
        axi_read(8'h1C, 32'h0, OKAY, "irq_rd0");
`endif

        // asynchronous reset while both channels are mid-handshake
        @(negedge clk);
        s_axi.awaddr  = 8'h08;
        s_axi.wdata   = 32'hDEAD_BEEF;
        s_axi.wstrb   = 4'hF;
        s_axi.awvalid = 1'b1;
        s_axi.wvalid  = 1'b1;
        s_axi.araddr  = 8'h08;
        s_axi.arvalid = 1'b1;
        @(negedge clk);
        check_val("mid_ready_pre", 64'({s_axi.awready, s_axi.arready}), 64'd3);
        #2 rst = 1'b1;
        #1 check_val("mid_rst_drop", 64'({s_axi.awready, s_axi.wready, s_axi.arready,
                                          s_axi.bvalid, s_axi.rvalid}), 64'h0);
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        s_axi.arvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_val("post_rst_ipreg", ipreg_data_o, {m_din_hi, m_din_lo});
        axi_read(8'h08, m_din_lo, OKAY, "post_rst_din_lo");
        axi_read(8'h18, m_cnt, OKAY, "post_rst_cnt");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/custom_axi_ip_regs.md
# custom_axi_ip_regs

AXI4-Lite slave register bank that sits directly upstream of the custom_axi_ip processing core. Software loads a 64-bit operand, starts the core, polls status, and reads back the 64-bit result. The block drives the core's data/enable inputs and captures its result on the core's write-enable pulse. It also keeps a completion counter and, optionally, a completion interrupt.

## Interface
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 8, AXI address width; only bits [4:2] are decoded.

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid / s_axi_awready  in/out  1  write address handshake
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
- s_axi_wvalid / s_axi_wready  in/out  1  write data handshake
- s_axi_bresp  out  2  OKAY=0, SLVERR=2
- s_axi_bvalid / s_axi_bready  out/in  1  write response handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid / s_axi_arready  in/out  1  read address handshake
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  OKAY/SLVERR
- s_axi_rvalid / s_axi_rready  out/in  1  read data handshake
- ipreg_data_o  out  64  {DATA_IN_HI, DATA_IN_LO} to core
- enable_o  out  1  one-cycle start pulse to core
- ipreg_data_i  in  64  core result
- status_i  in  status_e  core status, from custom_axi_ip_pkg (2-bit; IDLE=0, BUSY=1, DONE=2, ERROR=3)
- wen_i  in  1  core result-valid pulse
- irq_o  out  1  completion interrupt (only with CUSTOM_AXI_IP_REGS_IRQ_EN)

## Operation
- Register map (byte offsets):
  - 0x00 CTRL: bit0 START, write-1 pulses; reads 0.
  - 0x04 STATUS: RO; [1:0] = status_i.
  - 0x08 DATA_IN_LO: RW.
  - 0x0C DATA_IN_HI: RW.
  - 0x10 DATA_OUT_LO: RO.
  - 0x14 DATA_OUT_HI: RO.
  - 0x18 DONE_CNT: RO; 32-bit count that wraps 0xFFFFFFFF→0.
  - 0x1C IRQ: W1C; bit0 = DONE pending (macro only).
- Write FSM has three states: W_IDLE, W_ACK, W_RESP.
  - W_IDLE → W_ACK when awvalid and wvalid are both high.
  - In W_ACK, awready and wready are high together for 1 cycle and the write is performed. Go to W_RESP.
  - In W_RESP, bvalid is held until bready is seen, then return to W_IDLE.
  - awvalid without wvalid (or the reverse) waits; it is never accepted alone.
- Read FSM has three states: R_IDLE, R_ACK, R_DATA.
  - In R_ACK, arready is high for 1 cycle and rdata is registered.
  - In R_DATA, rvalid and rdata are held stable until rready is seen.
- WSTRB masks bytes on RW registers. A strobe of 0 still produces OKAY with no change.
- Response codes:
  - SLVERR on an unmapped offset or a write to an RO register; no state changes.
  - Unmapped reads return 0 with SLVERR.
- START handling:
  - With status_i==IDLE, START pulses enable_o for exactly 1 cycle; response OKAY.
  - Otherwise there is no pulse and the response is SLVERR.
- On wen_i: DATA_OUT ← ipreg_data_i, DONE_CNT += 1, and IRQ pending is set (macro).
- Writes to DATA_IN while the core is BUSY are accepted. They do not affect the operation in flight, because the core latched its operand at start.

## Timing
- Reset values: all AXI ready/valid outputs 0; bresp/rresp 0; rdata 0; ipreg_data_o 0; enable_o 0; DONE_CNT 0; DATA_OUT 0; irq_o 0; both FSMs idle.
- Write: awvalid&wvalid first seen at edge N → ready signals high in cycle N+1 → bvalid in cycle N+2. The register update is visible in cycle N+2.
- enable_o is high in cycle N+2 for a START write.
- Read: arvalid at edge N → arready in N+1 → rvalid in N+2, with data sampled at the N+1 edge.
- Back-to-back: the next address is not accepted until the previous response completes. Maximum rate is one transaction per 3 cycles per channel.
- The read and write FSMs are independent and may run concurrently.
- Collision rules:
  - If wen_i and a DATA_OUT read sample land on the same edge, the read returns the pre-capture value.
  - If wen_i and a W1C IRQ clear land on the same edge, set wins and pending stays 1.
- Asynchronous reset mid-transaction drops every in-flight handshake; valid signals deassert immediately.

## Configuration
- CUSTOM_AXI_IP_REGS_IRQ_EN defined:
  - IRQ register at 0x1C.
  - irq_o = pending bit, registered; it stays high until software writes 1 to clear.
- Not defined:
  - irq_o port absent.
  - 0x1C is unmapped (SLVERR on both read and write).

## Test plan
- Reset → all outputs 0; reads of DATA_IN_LO, DONE_CNT and STATUS all return 0 with OKAY.
- Write DATA_IN_LO=0x00000005, DATA_IN_HI=0x0000000A → ipreg_data_o=0x0000000A_00000005; a WSTRB=0x1 write of 0xFFFFFFFF to LO gives 0x000000FF-masked update 0x000000FF.
- START with status_i=IDLE → enable_o is a single-cycle pulse. START with status_i=BUSY → no pulse and bresp=SLVERR.
- wen_i pulse with ipreg_data_i=0x12345678_9ABCDEF0 → DATA_OUT_LO=0x9ABCDEF0, DATA_OUT_HI=0x12345678, DONE_CNT=1. After preloading the count to 0xFFFFFFFF via backdoor, the next wen_i makes it wrap to 0.
- Write to 0x04 and read of 0x3C → SLVERR; rdata=0; no register changes.
- With the macro defined: wen_i → irq_o=1. W1C to 0x1C on the same edge as a new wen_i → irq_o stays 1. A clean W1C → irq_o=0.
